// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational
// instruction memory and buffers words toward decode in a small queue.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  cur_pc,
  input  logic [31:0] IF_instruction,
  output logic [31:0] if_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        halt_req,
  output logic [1:0]  fetch_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // state | meaning: RUN fetching | FULL queue full, no fetch | HALTED stopped until flush
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FULL   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    qpc_q    [DEPTH];
  logic [31:0]    qinstr_q [DEPTH];
  logic           qfault_q [DEPTH];

  logic           id_valid_q, id_valid_d;
  logic [31:0]    id_instr_q, id_instr_d;
  logic [31:0]    id_pc_q, id_pc_d;
  logic           id_fault_q, id_fault_d;

  logic           flush, pop, enq, misaligned, head_from_enq;
  logic [31:0]    enq_instr;

  always_comb begin
    flush      = exc_req | redirect_valid;
    pop        = id_valid_q & id_ready;
    misaligned = (pc_q[1:0] != 2'b00);
    enq        = (state_q == ST_RUN) && ((count_q < DEPTH_C) || pop) && !flush && !halt_req;
    enq_instr  = misaligned ? 32'h0 : IF_instruction;

    pc_d    = pc_q;
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = exc_req ? EXC_VECTOR : redirect_target;
      state_d = ST_RUN;
    end else begin
      if (pop) head_d = head_q + 1'b1;
      if (enq) tail_d = tail_q + 1'b1;
      count_d = count_q + CW'(enq) - CW'(pop);
      if (enq && !misaligned) pc_d = pc_q + 32'd4;

      unique case (state_q)
        ST_RUN: begin
          if (halt_req || (enq && misaligned)) state_d = ST_HALTED;
          else if (count_d == DEPTH_C)         state_d = ST_FULL;
        end
        ST_FULL: begin
          if (halt_req) state_d = ST_HALTED;
          else if (pop) state_d = ST_RUN;
        end
        default: state_d = state_q;
      endcase
    end

    // The new head may be the word being written this cycle.
    head_from_enq = enq && (count_q == CW'(pop));
    id_valid_d    = (count_d != '0);
    id_pc_d       = id_pc_q;
    id_instr_d    = 32'h0;
    id_fault_d    = 1'b0;
    if (id_valid_d) begin
      id_pc_d    = head_from_enq ? pc_q       : qpc_q[head_d];
      id_instr_d = head_from_enq ? enq_instr  : qinstr_q[head_d];
      id_fault_d = head_from_enq ? misaligned : qfault_q[head_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= 32'h0;
      id_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_fault_q <= id_fault_d;
      if (enq) begin
        qpc_q[tail_q]    <= pc_q;
        qinstr_q[tail_q] <= enq_instr;
        qfault_q[tail_q] <= misaligned;
      end
    end
  end

  assign cur_pc      = pc_q[11:2];
  assign if_pc       = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_fault    = id_fault_q;
  assign fetch_state = state_q;

endmodule
